dvs_cdma_core: RTL and testbench
================================

// Module: dvs_cdma_core
// PURPOSE
//  Emulates a dynamic-vision sensor on a parallel camera stream (pclk/vsync/href/pix_data).
//  For each strobed pixel, reads that pixel's reference brightness from a line-buffer BRAM.
//  Emits an ON/OFF event when the brightness change meets a threshold, and writes the result
//  word back to BRAM. Line/frame pulses let an external CDMA move lines between BRAM and DDR.
// PARAMETERS
//  LINE_PIXELS  640  pixels per line; also the depth of each BRAM line bank
//  ADDR_W       17   BRAM byte-address width
// PORTS
//  pclk            in   1       sole clock; BRAM clock is taken from it
//  reset           in   1       synchronous, active-low reset
//  vsync           in   1       frame sync; rising edge starts a frame
//  href            in   1       line valid; falling edge ends a line
//  pix_data        in   8       current pixel brightness
//  write_enable_in in   1       one-cycle pixel strobe
//  threshold       in   8       event threshold
//  new_frame       out  1       1-cycle pulse on vsync rise
//  read_new_line   out  1       1-cycle pulse: CDMA must fill the freed read bank
//  write_new_line  out  1       1-cycle pulse: CDMA must drain the finished write bank
//  bram_addr       out  ADDR_W  byte address, word aligned
//  bram_clk        out  1       = pclk
//  bram_wrdata     out  32      result word
//  bram_rddata     in   32      reference word; 1-cycle read latency
//  bram_en         out  1       BRAM enable
//  bram_rst        out  1       = ~reset
//  bram_we         out  4       byte write enables
// BEHAVIOUR
//  - Reset (reset==0 at an edge): all outputs 0 except bram_rst=1. Pixel index, bank select
//    and edge registers clear. A reset mid-line abort the pending write; it is not issued.
//  - vsync rise: new_frame=1 for 1 cycle; pixel index=0; bank=0. If it coincides with an
//    href fall, the frame restart wins: no line pulses.
//  - BRAM map, one 32-bit word per pixel, LB=LINE_PIXELS*4:
//    - read bank b at b*LB; write bank b at (2+b)*LB.
//  - Pixel pipeline: 2 cycles per pixel; a strobe is accepted only when href=1, the pipeline
//    is idle and the pixel index is < LINE_PIXELS.
//    - Cycle T (strobe): combinational bram_en=1, bram_we=0, bram_addr=read address;
//      pix_data is latched.
//    - Cycle T+1: ref=bram_rddata[15:8]. d=|pix-ref|, 9-bit unsigned.
//      - Event when d>=threshold; threshold 0 means every pixel is an event.
//      - ON when pix>ref, else OFF.
//      - Registered write: bram_en=1, bram_we=4'hF, address = write bank + same offset.
//        wrdata = {14'b0, on, off, newref, pix}.
//      - newref = pix on event, else ref.
//      - The pixel index then increments.
//    - A strobe during T+1 is dropped. Strobes past LINE_PIXELS are dropped.
//  - href fall: in the following cycle write_new_line=1 and read_new_line=1.
//    Bank toggles and the pixel index clears.
//  - No handshake with the CDMA: it must service a bank within one line time.
// CONFIGURATION
//  - DVS_EVENT_COUNT_EN defined: adds output event_count[15:0].
//    - Counts events in the frame; saturates at 16'hFFFF.
//    - Cleared on reset and on new_frame.
//  - DVS_EVENT_COUNT_EN undefined: the port and counter are absent; all else is identical.
// STRUCTURE
//  - Package dvs_cdma_pkg holds:
//    - word field positions: PIX=[7:0], REF=[15:8], OFF=16, ON=17;
//    - bank base constants;
//    - the pipeline state enum {IDLE, WRITE}.
//  - Sub-module dvs_event_cmp: combinational; ports pix, ref, threshold -> on, off, newref.
// TESTING
//  1 threshold=12, rddata=0: pix 10 -> wrdata 0x0000_000A, we=F, write address 2*LB+0.
//  2 threshold=12, rddata=0: pix 20 -> ON event, wrdata 0x0002_1414.
//  3 threshold=12, rddata=0x2800: pix 10 -> OFF, wrdata 0x0001_0A0A.
//    pix 20 -> OFF, wrdata 0x0001_1414.
//  4 vsync pulse -> new_frame high exactly 1 cycle.
//    Four href lines -> line pulses after each fall; read base alternates 0, LB, 0, LB.
//  5 Strobes on consecutive cycles -> the second is dropped.
//    reset=0 mid-pipeline -> no write; outputs 0, bram_rst=1.
//  6 threshold=0, pix==ref -> OFF event.
//    With DVS_EVENT_COUNT_EN, event_count increments on each event and clears on vsync.

Source files
------------

// File: rtl/dvs_cdma_pkg.sv
// Shared constants, word layout and pipeline state for the DVS line-buffer core.
// Optional build macro used by the core: DVS_EVENT_COUNT_EN.
package dvs_cdma_pkg;

    localparam int PIX_LSB = 0;
    localparam int PIX_MSB = 7;
    localparam int REF_LSB = 8;
    localparam int REF_MSB = 15;
    localparam int OFF_BIT = 16;
    localparam int ON_BIT  = 17;

    // Bank bases in units of one line bank; read banks sit below the write banks.
    localparam int RD_BANK_BASE = 0;
    localparam int WR_BANK_BASE = 2;

    typedef enum logic {
        IDLE,
        WRITE
    } pipe_state_t;

    function automatic logic [31:0] pack_word(input logic on, input logic off,
                                              input logic [7:0] newref, input logic [7:0] pix);
        logic [31:0] w;
        w = '0;
        w[PIX_MSB:PIX_LSB] = pix;
        w[REF_MSB:REF_LSB] = newref;
        w[OFF_BIT]         = off;
        w[ON_BIT]          = on;
        return w;
    endfunction

endpackage

// File: rtl/dvs_event_cmp.sv
// Combinational brightness-change comparator: flags ON/OFF events and picks the new reference.
// The reference input is named ref_val because "ref" is a reserved word.
module dvs_event_cmp (
    input  logic [7:0] pix,
    input  logic [7:0] ref_val,
    input  logic [7:0] threshold,
    output logic       on,
    output logic       off,
    output logic [7:0] newref
);

    logic       brighter;
    logic       hit;
    logic [8:0] diff;

    // A threshold of zero makes every pixel an event; equal brightness counts as OFF.
    always_comb begin
        brighter = pix > ref_val;
        diff     = brighter ? ({1'b0, pix} - {1'b0, ref_val})
                            : ({1'b0, ref_val} - {1'b0, pix});
        hit      = diff >= {1'b0, threshold};
        on       = hit & brighter;
        off      = hit & ~brighter;
        newref   = hit ? pix : ref_val;
    end

endmodule

// File: rtl/dvs_cdma_core.sv
// DVS emulator core: two-cycle read/compare/write pixel pipeline over ping-pong BRAM line banks.
// Define DVS_EVENT_COUNT_EN to add the saturating per-frame event_count output.
module dvs_cdma_core
    import dvs_cdma_pkg::*;
#(
    parameter int LINE_PIXELS = 640,
    parameter int ADDR_W      = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        pix_data,
    input  logic              write_enable_in,
    input  logic [7:0]        threshold,
    output logic              new_frame,
    output logic              read_new_line,
    output logic              write_new_line,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_clk,
    output logic [31:0]       bram_wrdata,
    input  logic [31:0]       bram_rddata,
    output logic              bram_en,
    output logic              bram_rst,
`ifdef DVS_EVENT_COUNT_EN
    output logic [15:0]       event_count,
`endif
    output logic [3:0]        bram_we
);

    localparam int                IDX_W     = $clog2(LINE_PIXELS + 1);
    localparam logic [IDX_W-1:0]  IDX_LIMIT = IDX_W'(LINE_PIXELS);
    localparam int                LB        = LINE_PIXELS * 4;
    localparam logic [ADDR_W-1:0] RD_BASE0  = ADDR_W'(RD_BANK_BASE * LB);
    localparam logic [ADDR_W-1:0] RD_BASE1  = ADDR_W'((RD_BANK_BASE + 1) * LB);
    localparam logic [ADDR_W-1:0] WR_BASE0  = ADDR_W'(WR_BANK_BASE * LB);
    localparam logic [ADDR_W-1:0] WR_BASE1  = ADDR_W'((WR_BANK_BASE + 1) * LB);

    pipe_state_t       state;
    logic [IDX_W-1:0]  pix_idx;
    logic              bank;
    logic              bank_lat;
    logic              vsync_d;
    logic              href_d;
    logic [7:0]        pix_lat;
    logic [ADDR_W-1:0] off_lat;
    logic [ADDR_W-1:0] cur_off;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              vsync_rise;
    logic              href_fall;
    logic              accept;
    logic              write_active;
    logic              ev_on;
    logic              ev_off;
    logic [7:0]        newref;
    logic              unused_rddata;

    assign bram_clk      = pclk;
    assign bram_rst      = ~reset;
    assign unused_rddata = ^{bram_rddata[31:REF_MSB+1], bram_rddata[REF_LSB-1:0]};

    assign vsync_rise   = vsync & ~vsync_d;
    assign href_fall    = ~href & href_d;
    assign accept       = reset & write_enable_in & href & (state == IDLE) & (pix_idx < IDX_LIMIT);
    assign write_active = reset & (state == WRITE);

    assign cur_off = ADDR_W'({pix_idx, 2'b00});
    assign rd_addr = (bank ? RD_BASE1 : RD_BASE0) + cur_off;
    assign wr_addr = (bank_lat ? WR_BASE1 : WR_BASE0) + off_lat;

    dvs_event_cmp u_cmp (
        .pix       (pix_lat),
        .ref_val   (bram_rddata[REF_MSB:REF_LSB]),
        .threshold (threshold),
        .on        (ev_on),
        .off       (ev_off),
        .newref    (newref)
    );

    // The read goes out combinationally in the strobe cycle; the write follows in the compare cycle.
    always_comb begin
        bram_en     = 1'b0;
        bram_we     = 4'h0;
        bram_addr   = '0;
        bram_wrdata = '0;
        if (write_active) begin
            bram_en     = 1'b1;
            bram_we     = 4'hF;
            bram_addr   = wr_addr;
            bram_wrdata = pack_word(ev_on, ev_off, newref, pix_lat);
        end else if (accept) begin
            bram_en   = 1'b1;
            bram_addr = rd_addr;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state          <= IDLE;
            pix_idx        <= '0;
            bank           <= 1'b0;
            bank_lat       <= 1'b0;
            vsync_d        <= 1'b0;
            href_d         <= 1'b0;
            pix_lat        <= '0;
            off_lat        <= '0;
            new_frame      <= 1'b0;
            read_new_line  <= 1'b0;
            write_new_line <= 1'b0;
        end else begin
            vsync_d        <= vsync;
            href_d         <= href;
            new_frame      <= vsync_rise;
            read_new_line  <= href_fall & ~vsync_rise;
            write_new_line <= href_fall & ~vsync_rise;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= WRITE;
                        pix_lat  <= pix_data;
                        off_lat  <= cur_off;
                        bank_lat <= bank;
                    end
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Frame restart outranks the line-end bank swap.
            if (vsync_rise) begin
                pix_idx <= '0;
                bank    <= 1'b0;
            end else if (href_fall) begin
                pix_idx <= '0;
                bank    <= ~bank;
            end else if (state == WRITE) begin
                pix_idx <= pix_idx + 1'b1;
            end
        end
    end

`ifdef DVS_EVENT_COUNT_EN
    always_ff @(posedge pclk) begin
        if (!reset || vsync_rise) begin
            event_count <= '0;
        end else if (write_active && (ev_on || ev_off) && event_count != 16'hFFFF) begin
            event_count <= event_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dvs_cdma_core.sv
// Directed self-checking bench for dvs_cdma_core; event_count checks build with DVS_EVENT_COUNT_EN.
module tb_dvs_cdma_core;

    localparam int LINE_PIXELS = 640;
    localparam int ADDR_W      = 17;
    localparam int LB          = LINE_PIXELS * 4;
    localparam int WB0         = 2 * LB;

    logic              pclk = 1'b0;
    logic              reset;
    logic              vsync;
    logic              href;
    logic [7:0]        pix_data;
    logic              write_enable_in;
    logic [7:0]        threshold;
    logic              new_frame;
    logic              read_new_line;
    logic              write_new_line;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_clk;
    logic [31:0]       bram_wrdata;
    logic [31:0]       bram_rddata;
    logic              bram_en;
    logic              bram_rst;
    logic [3:0]        bram_we;
`ifdef DVS_EVENT_COUNT_EN
    logic [15:0]       event_count;
`endif

    int tests    = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    dvs_cdma_core #(.LINE_PIXELS(LINE_PIXELS), .ADDR_W(ADDR_W)) dut (
        .pclk            (pclk),
        .reset           (reset),
        .vsync           (vsync),
        .href            (href),
        .pix_data        (pix_data),
        .write_enable_in (write_enable_in),
        .threshold       (threshold),
        .new_frame       (new_frame),
        .read_new_line   (read_new_line),
        .write_new_line  (write_new_line),
        .bram_addr       (bram_addr),
        .bram_clk        (bram_clk),
        .bram_wrdata     (bram_wrdata),
        .bram_rddata     (bram_rddata),
        .bram_en         (bram_en),
        .bram_rst        (bram_rst),
`ifdef DVS_EVENT_COUNT_EN
        .event_count     (event_count),
`endif
        .bram_we         (bram_we)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One pixel: strobe cycle checks the read, next cycle checks the write-back.
    task automatic applyStimulus(input logic [7:0] pix, input logic [31:0] rd,
                                 input int rd_addr, input int wr_addr,
                                 input logic [31:0] wd, input string tag);
        @(negedge pclk);
        write_enable_in = 1'b1;
        pix_data        = pix;
        bram_rddata     = ~rd;
        #1;
        checkOutput({tag, " rd_en"}, 32'(bram_en), 32'd1);
        checkOutput({tag, " rd_we"}, 32'(bram_we), 32'd0);
        checkOutput({tag, " rd_addr"}, 32'(bram_addr), rd_addr);
        @(negedge pclk);
        write_enable_in = 1'b0;
        bram_rddata     = rd;
        #1;
        checkOutput({tag, " wr_en"}, 32'(bram_en), 32'd1);
        checkOutput({tag, " wr_we"}, 32'(bram_we), 32'hF);
        checkOutput({tag, " wr_addr"}, 32'(bram_addr), wr_addr);
        checkOutput({tag, " wrdata"}, bram_wrdata, wd);
    endtask

    initial begin
        reset = 1'b0; vsync = 1'b0; href = 1'b0; pix_data = '0;
        write_enable_in = 1'b0; threshold = 8'd12; bram_rddata = '0;

        // Reset: strobe ignored, all outputs quiet, bram_rst high
        @(negedge pclk);
        @(negedge pclk);
        write_enable_in = 1'b1; href = 1'b1;
        #1;
        checkOutput("rst bram_en", 32'(bram_en), 32'd0);
        checkOutput("rst bram_addr", 32'(bram_addr), 32'd0);
        checkOutput("rst bram_rst", 32'(bram_rst), 32'd1);
        checkOutput("rst new_frame", 32'(new_frame), 32'd0);
        checkOutput("rst line pulses", 32'({read_new_line, write_new_line}), 32'd0);
        write_enable_in = 1'b0; href = 1'b0; reset = 1'b1;
        @(negedge pclk);
        #1;
        checkOutput("run bram_rst", 32'(bram_rst), 32'd0);

        // Frame start pulse
        vsync = 1'b1;
        @(negedge pclk);
        #1;
        checkOutput("vsync new_frame hi", 32'(new_frame), 32'd1);
`ifdef DVS_EVENT_COUNT_EN
        checkOutput("vsync count", 32'(event_count), 32'd0);
`endif
        vsync = 1'b0;
        @(negedge pclk);
        #1;
        checkOutput("vsync new_frame lo", 32'(new_frame), 32'd0);

        // Threshold 12 against reference 0 and 0x28
        href = 1'b1;
        applyStimulus(8'd10, 32'h0, 0, WB0 + 0, 32'h0000_000A, "t1 pix10");
        applyStimulus(8'd20, 32'h0, 4, WB0 + 4, 32'h0002_1414, "t2 pix20 on");
`ifdef DVS_EVENT_COUNT_EN
        @(negedge pclk); #1;
        checkOutput("count after on", 32'(event_count), 32'd1);
`endif
        applyStimulus(8'd10, 32'h2800, 8, WB0 + 8, 32'h0001_0A0A, "t3 pix10 off");
        applyStimulus(8'd20, 32'h2800, 12, WB0 + 12, 32'h0001_1414, "t3 pix20 off");
`ifdef DVS_EVENT_COUNT_EN
        @(negedge pclk); #1;
        checkOutput("count after off", 32'(event_count), 32'd3);
`endif
        threshold = 8'd0;
        applyStimulus(8'h28, 32'h2800, 16, WB0 + 16, 32'h0001_2828, "t6 thr0 equal");
`ifdef DVS_EVENT_COUNT_EN
        @(negedge pclk); #1;
        checkOutput("count thr0", 32'(event_count), 32'd4);
`endif

        // Second vsync clears the frame; then four lines alternate banks
        @(negedge pclk);
        vsync = 1'b1;
        @(negedge pclk);
        #1;
        checkOutput("vsync2 new_frame", 32'(new_frame), 32'd1);
`ifdef DVS_EVENT_COUNT_EN
        checkOutput("vsync2 count clr", 32'(event_count), 32'd0);
`endif
        vsync = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(8'h30, 32'h3000, (k % 2) * LB, WB0 + (k % 2) * LB, 32'h0001_3030, $sformatf("line%0d", k));
            @(negedge pclk);
            href = 1'b0;
            @(negedge pclk);
            #1;
            checkOutput($sformatf("line%0d pulses", k), 32'({read_new_line, write_new_line}), 32'd3);
            href = 1'b1;
            @(negedge pclk);
            #1;
            checkOutput($sformatf("line%0d pulses end", k), 32'({read_new_line, write_new_line}), 32'd0);
        end

        // href fall and vsync rise together: restart wins, bank stays 0
        applyStimulus(8'h30, 32'h3000, 0, WB0, 32'h0001_3030, "coinc pre");
        @(negedge pclk);
        href = 1'b0; vsync = 1'b1;
        @(negedge pclk);
        #1;
        checkOutput("coinc new_frame", 32'(new_frame), 32'd1);
        checkOutput("coinc no pulses", 32'({read_new_line, write_new_line}), 32'd0);
        href = 1'b1; vsync = 1'b0;
        applyStimulus(8'h30, 32'h3000, 0, WB0, 32'h0001_3030, "coinc post");

        // Back-to-back strobes: second dropped, index advances by one
        @(negedge pclk);
        write_enable_in = 1'b1; pix_data = 8'd7; bram_rddata = 32'h0;
        #1;
        checkOutput("b2b rd_addr", 32'(bram_addr), 32'd4);
        @(negedge pclk);
        pix_data = 8'd9; bram_rddata = 32'h2800;
        #1;
        checkOutput("b2b wr_addr", 32'(bram_addr), WB0 + 4);
        checkOutput("b2b wrdata", bram_wrdata, 32'h0001_0707);
        @(negedge pclk);
        write_enable_in = 1'b0;
        #1;
        checkOutput("b2b dropped", 32'(bram_en), 32'd0);

        // Reset in the compare cycle suppresses the write
        @(negedge pclk);
        write_enable_in = 1'b1; pix_data = 8'd50;
        #1;
        checkOutput("abort rd_addr", 32'(bram_addr), 32'd8);
        @(negedge pclk);
        write_enable_in = 1'b0; reset = 1'b0;
        #1;
        checkOutput("abort bram_en", 32'(bram_en), 32'd0);
        checkOutput("abort bram_we", 32'(bram_we), 32'd0);
        checkOutput("abort wrdata", bram_wrdata, 32'd0);
        checkOutput("abort bram_rst", 32'(bram_rst), 32'd1);
        @(negedge pclk);
        reset = 1'b1;
        #1;
        checkOutput("post rst idle", 32'(bram_en), 32'd0);
`ifdef DVS_EVENT_COUNT_EN
        checkOutput("post rst count", 32'(event_count), 32'd0);
`endif

        // Fill a full line; the strobe past the end is ignored
        for (int i = 0; i < LINE_PIXELS; i++) begin
            @(negedge pclk);
            write_enable_in = 1'b1; pix_data = 8'(i);
            @(negedge pclk);
            write_enable_in = 1'b0;
            if (i == LINE_PIXELS - 1) begin
                #1;
                checkOutput("last wr_addr", 32'(bram_addr), WB0 + (LINE_PIXELS - 1) * 4);
            end
        end
        @(negedge pclk);
        write_enable_in = 1'b1;
        #1;
        checkOutput("overflow dropped", 32'(bram_en), 32'd0);
        @(negedge pclk);
        write_enable_in = 1'b0; href = 1'b0;
        @(negedge pclk);
        #1;
        checkOutput("full line pulses", 32'({read_new_line, write_new_line}), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
